// File: rtl/mem_pkg.sv
// mem_pkg: shared memory-system types for the D$ port arbiter
package mem_pkg;
   localparam int DC_ADDR_W = 64;
   localparam int DC_DATA_W = 64;
   localparam logic [1:0] WLEN_DWORD = 2'd3;
   typedef enum logic [1:0] {IDLE, BUSY_C, BUSY_P, DRAIN} dcarb_state_t;
   typedef struct packed {
      logic                 en;
      logic [DC_ADDR_W-1:0] addr;
      logic                 write;
      logic [DC_DATA_W-1:0] wdata;
      logic [1:0]           wlen;
      logic                 virt;
   } dc_req_t;
endpackage

// File: rtl/dcarb_starve_ctr.sv
// dcarb_starve_ctr: saturating count of walker grants taken while the core waits
module dcarb_starve_ctr #(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);
   localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
   logic [W-1:0] cnt;
   // a core grant restarts the count; walker grants over a waiting core saturate it
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc && !at_limit) cnt <= cnt + 1'b1;
   assign at_limit = cnt == W'(LIMIT);
endmodule

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the D$ request port between core (C) and walker (P); DCARB_PERF_EN adds perf counters
module dcache_port_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH   = 64,
   parameter int DATA_WIDTH   = 64,
   parameter int STARVE_LIMIT = 4
`ifdef DCARB_PERF_EN
   ,parameter int CNT_WIDTH   = 32
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  virtual_en,
   input  logic                  c_req,
   input  logic [ADDR_WIDTH-1:0] c_addr,
   input  logic                  c_write,
   input  logic [DATA_WIDTH-1:0] c_wdata,
   input  logic [1:0]            c_wlen,
   output logic [DATA_WIDTH-1:0] c_rdata,
   output logic                  c_resp,
   input  logic                  p_req,
   input  logic [ADDR_WIDTH-1:0] p_addr,
   output logic [DATA_WIDTH-1:0] p_rdata,
   output logic                  p_resp,
   output logic                  dc_en,
   output logic [ADDR_WIDTH-1:0] dc_addr,
   output logic                  dc_write,
   output logic [DATA_WIDTH-1:0] dc_wdata,
   output logic [1:0]            dc_wlen,
   output logic                  dc_virtual,
   input  logic [DATA_WIDTH-1:0] dc_rdata,
   input  logic                  dc_rvalid,
   input  logic                  dc_write_done
`ifdef DCARB_PERF_EN
   ,output logic [CNT_WIDTH-1:0] perf_c_grants,
   output logic [CNT_WIDTH-1:0]  perf_p_grants,
   output logic [CNT_WIDTH-1:0]  perf_c_stall
`endif
);
   dcarb_state_t state, next;
   dc_req_t      req;
   logic         done, grant_c, grant_p, at_limit;
   // state register; reset abandons any in-flight D$ access
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= next;
   // arbitration, completion detection and the D$ request mux
   always_comb begin
      next = state;
      req  = '0;
      done = 1'b0;
      case (state)
         IDLE: next = (p_req && !(c_req && at_limit)) ? BUSY_P : c_req ? BUSY_C : IDLE;
         BUSY_C: begin
            req  = '{en: 1'b1, addr: DC_ADDR_W'(c_addr), write: c_write,
                     wdata: DC_DATA_W'(c_wdata), wlen: c_wlen, virt: virtual_en};
            done = c_write ? dc_write_done : dc_rvalid;
            next = done ? DRAIN : BUSY_C;
         end
         BUSY_P: begin
            req  = '{en: 1'b1, addr: DC_ADDR_W'(p_addr), write: 1'b0,
                     wdata: '0, wlen: WLEN_DWORD, virt: 1'b0};
            done = dc_rvalid;
            next = done ? DRAIN : BUSY_P;
         end
         default: next = IDLE;
      endcase
   end
   assign grant_c    = state == IDLE && next == BUSY_C;
   assign grant_p    = state == IDLE && next == BUSY_P;
   assign c_resp     = state == BUSY_C && done;
   assign p_resp     = state == BUSY_P && done;
   assign c_rdata    = c_resp ? dc_rdata : '0;
   assign p_rdata    = p_resp ? dc_rdata : '0;
   assign dc_en      = req.en;
   assign dc_addr    = req.addr[ADDR_WIDTH-1:0];
   assign dc_write   = req.write;
   assign dc_wdata   = req.wdata[DATA_WIDTH-1:0];
   assign dc_wlen    = req.wlen;
   assign dc_virtual = req.virt;
   dcarb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk      (clk),
      .reset    (reset),
      .inc      (grant_p && c_req),
      .clr      (grant_c),
      .at_limit (at_limit)
   );
`ifdef DCARB_PERF_EN
   // grant and core-stall event counters, wrapping modulo 2^CNT_WIDTH
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         perf_c_grants <= '0;
         perf_p_grants <= '0;
         perf_c_stall  <= '0;
      end else begin
         perf_c_grants <= perf_c_grants + CNT_WIDTH'(grant_c);
         perf_p_grants <= perf_p_grants + CNT_WIDTH'(grant_p);
         perf_c_stall  <= perf_c_stall + CNT_WIDTH'(c_req && state != BUSY_C);
      end
`endif
   // a granted requester must hold its request until its response
   assert property (@(posedge clk) disable iff (!reset) (state == BUSY_C) |-> c_req);
   assert property (@(posedge clk) disable iff (!reset) (state == BUSY_P) |-> p_req);
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_dcache_port_arbiter;
   localparam int AW = 64, DW = 64, LIM = 4;
   logic clk = 0, reset = 0, virtual_en = 0, c_req = 0, c_write = 0, p_req = 0;
   logic dc_rvalid = 0, dc_write_done = 0;
   logic [AW-1:0] c_addr = '0, p_addr = '0;
   logic [DW-1:0] c_wdata = '0, dc_rdata = '0;
   logic [1:0] c_wlen = '0;
   logic [DW-1:0] c_rdata, p_rdata, dc_wdata;
   logic [AW-1:0] dc_addr;
   logic c_resp, p_resp, dc_en, dc_write, dc_virtual;
   logic [1:0] dc_wlen;
`ifdef DCARB_PERF_EN
   logic [31:0] perf_c_grants, perf_p_grants, perf_c_stall;
`endif
   int checks = 0, errors = 0;
   // model: owner 0=none 1=core 2=walker; gap = idle cycle owed after a completion
   int owner = 0, p_run = 0, n_cg = 0, n_pg = 0, n_stall = 0;
   bit gap = 0, exp_c_resp = 0, exp_p_resp = 0;

   dcache_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)
`ifdef DCARB_PERF_EN
      , .CNT_WIDTH(32)
`endif
   ) dut (
      .clk(clk), .reset(reset), .virtual_en(virtual_en),
      .c_req(c_req), .c_addr(c_addr), .c_write(c_write), .c_wdata(c_wdata), .c_wlen(c_wlen),
      .c_rdata(c_rdata), .c_resp(c_resp),
      .p_req(p_req), .p_addr(p_addr), .p_rdata(p_rdata), .p_resp(p_resp),
      .dc_en(dc_en), .dc_addr(dc_addr), .dc_write(dc_write), .dc_wdata(dc_wdata),
      .dc_wlen(dc_wlen), .dc_virtual(dc_virtual),
      .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_write_done(dc_write_done)
`ifdef DCARB_PERF_EN
      , .perf_c_grants(perf_c_grants), .perf_p_grants(perf_p_grants), .perf_c_stall(perf_c_stall)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_check();
      bit done;
      done = (owner == 1) ? (c_write ? dc_write_done : dc_rvalid) : (owner == 2) && dc_rvalid;
      exp_c_resp = owner == 1 && done;
      exp_p_resp = owner == 2 && done;
      check("dc_en", 64'(dc_en), 64'(owner != 0));
      check("dc_addr", dc_addr, owner == 1 ? c_addr : owner == 2 ? p_addr : 64'd0);
      check("dc_write", 64'(dc_write), 64'(owner == 1 && c_write));
      check("dc_wdata", dc_wdata, owner == 1 ? c_wdata : 64'd0);
      check("dc_wlen", 64'(dc_wlen), owner == 1 ? 64'(c_wlen) : owner == 2 ? 64'd3 : 64'd0);
      check("dc_virtual", 64'(dc_virtual), 64'(owner == 1 && virtual_en));
      check("c_resp", 64'(c_resp), 64'(exp_c_resp));
      check("p_resp", 64'(p_resp), 64'(exp_p_resp));
      if (owner != 1 || exp_c_resp) check("c_rdata", c_rdata, exp_c_resp ? dc_rdata : 64'd0);
      if (owner != 2 || exp_p_resp) check("p_rdata", p_rdata, exp_p_resp ? dc_rdata : 64'd0);
   endtask

   task automatic model_next();
      if (c_req && owner != 1) n_stall++;
      if (exp_c_resp || exp_p_resp) begin
         owner = 0;
         gap = 1;
      end else if (owner == 0) begin
         if (gap) gap = 0;
         else if (p_req && !(c_req && p_run >= LIM)) begin
            owner = 2;
            n_pg++;
            if (c_req) p_run++;
         end else if (c_req) begin
            owner = 1;
            n_cg++;
            p_run = 0;
         end
      end
   endtask

   task automatic cyc();
      #1;
      model_check();
      model_next();
      @(posedge clk);
      #1;
   endtask

   task automatic drain_reqs();
      for (int i = 0; i < 30 && (c_req || p_req); i++) begin
         dc_rvalid = 1;
         dc_write_done = 1;
         dc_rdata = {$urandom, $urandom};
         cyc();
         if (exp_c_resp) c_req = 0;
         if (exp_p_resp) p_req = 0;
      end
      check("drain_done", 64'(c_req || p_req), 64'd0);
      c_req = 0;
      p_req = 0;
      dc_rvalid = 0;
      dc_write_done = 0;
      cyc();
      cyc();
   endtask

   initial begin
      int np;
      bit c_seen, got_c, got_p, c_drop, p_drop;
      @(posedge clk);
      #1;
      check("rst_dc_en", 64'(dc_en), 64'd0);
      check("rst_c_resp", 64'(c_resp), 64'd0);
      check("rst_p_resp", 64'(p_resp), 64'd0);
      check("rst_dc_addr", dc_addr, 64'd0);
      @(posedge clk);
      #1;
      reset = 1;

      // core-only read, D$ answers 3 cycles after dc_en rises
      c_req = 1; c_addr = 'h1000; c_write = 0; virtual_en = 1;
      cyc();
      check("rd_en", 64'(dc_en), 64'd1);
      check("rd_addr", dc_addr, 64'h1000);
      cyc(); cyc(); cyc();
      dc_rvalid = 1; dc_rdata = 'hDEAD;
      #1;
      check("rd_resp", 64'(c_resp), 64'd1);
      check("rd_rdata", c_rdata, 64'hDEAD);
      cyc();
      dc_rvalid = 0; c_req = 0;
      check("rd_drain", 64'(dc_en), 64'd0);
      cyc(); cyc();

      // simultaneous requests: walker first, then core
      c_req = 1; c_addr = 'h2000; p_req = 1; p_addr = 'h8000; virtual_en = 1;
      cyc();
      check("sim_p_addr", dc_addr, 64'h8000);
      check("sim_p_virt", 64'(dc_virtual), 64'd0);
      check("sim_p_wlen", 64'(dc_wlen), 64'd3);
      dc_rvalid = 1; dc_rdata = 'h1234;
      #1;
      check("sim_p_resp", 64'(p_resp), 64'd1);
      check("sim_p_rdata", p_rdata, 64'h1234);
      check("sim_c_quiet", 64'(c_resp), 64'd0);
      cyc();
      dc_rvalid = 0; p_req = 0;
      cyc(); cyc();
      check("sim_c_addr", dc_addr, 64'h2000);
      check("sim_c_virt", 64'(dc_virtual), 64'd1);
      drain_reqs();

      // starvation: core held, walker re-raises at every opportunity
      c_req = 1; c_addr = 'h3000; p_req = 1; p_addr = 'h9000; dc_rvalid = 1;
      np = 0; c_seen = 0;
      for (int i = 0; i < 60 && !c_seen; i++) begin
         #1;
         got_p = p_resp;
         got_c = c_resp;
         cyc();
         if (got_p) np++;
         p_req = !got_p;
         if (got_c) begin
            c_seen = 1;
            c_req = 0;
         end
      end
      check("starve_p_grants", 64'(np), 64'd4);
      check("starve_c_seen", 64'(c_seen), 64'd1);
      drain_reqs();
      c_req = 1; c_addr = 'h3100; p_req = 1; p_addr = 'h9100;
      cyc();
      check("starve_cleared", dc_addr, 64'h9100);
      drain_reqs();

      // core write: spurious rvalid ignored, completion on write_done
      c_req = 1; c_write = 1; c_wlen = 2; c_wdata = 'h55; c_addr = 'h4000;
      cyc();
      check("wr_write", 64'(dc_write), 64'd1);
      check("wr_wdata", dc_wdata, 64'h55);
      check("wr_wlen", 64'(dc_wlen), 64'd2);
      dc_rvalid = 1;
      #1;
      check("wr_spurious", 64'(c_resp), 64'd0);
      cyc();
      dc_rvalid = 0; dc_write_done = 1;
      #1;
      check("wr_resp", 64'(c_resp), 64'd1);
      cyc();
      dc_write_done = 0; c_req = 0; c_write = 0;
      cyc(); cyc();

      // reset in the middle of a core access
      c_req = 1; c_addr = 'h5000;
      cyc();
      check("mid_busy", 64'(dc_en), 64'd1);
      dc_rvalid = 1;
      reset = 0;
      #1;
      check("mid_rst_en", 64'(dc_en), 64'd0);
      check("mid_rst_resp", 64'(c_resp), 64'd0);
      check("mid_rst_addr", dc_addr, 64'd0);
      check("mid_rst_virt", 64'(dc_virtual), 64'd0);
      owner = 0; gap = 0; p_run = 0; n_cg = 0; n_pg = 0; n_stall = 0;
      c_req = 0; dc_rvalid = 0; p_req = 1; p_addr = 'hA000;
      @(posedge clk);
      #2;
      reset = 1;
      cyc();
      check("mid_p_grant", 64'(dc_en), 64'd1);
      check("mid_p_addr", dc_addr, 64'hA000);
      drain_reqs();

      // randomized traffic under the requester protocol
      c_drop = 0; p_drop = 0;
      for (int i = 0; i < 3000; i++) begin
         if (c_drop) begin
            c_req = 0;
            c_drop = 0;
         end else if (!c_req && $urandom_range(2) != 0) begin
            c_req = 1;
            c_addr = {$urandom, $urandom};
            c_write = 1'($urandom);
            c_wdata = {$urandom, $urandom};
            c_wlen = 2'($urandom);
         end
         if (p_drop) begin
            p_req = 0;
            p_drop = 0;
         end else if (!p_req && $urandom_range(3) != 0) begin
            p_req = 1;
            p_addr = {$urandom, $urandom};
         end
         virtual_en = 1'($urandom);
         dc_rvalid = $urandom_range(2) == 0;
         dc_write_done = $urandom_range(2) == 0;
         dc_rdata = {$urandom, $urandom};
         cyc();
         if (exp_c_resp) c_drop = 1;
         if (exp_p_resp) p_drop = 1;
      end
      drain_reqs();

`ifdef DCARB_PERF_EN
      check("perf_c_grants", 64'(perf_c_grants), 64'(32'(n_cg)));
      check("perf_p_grants", 64'(perf_p_grants), 64'(32'(n_pg)));
      check("perf_c_stall", 64'(perf_c_stall), 64'(32'(n_stall)));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
